// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: locks onto incoming hsync/vsync and
// regenerates active-area pixel coordinates, an active-video flag and lock status.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       display,
  output logic       locked,
  output logic       frame_start,
  output logic       err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic        ACT     = (SYNC_POL != 0);
  localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_TOT11 = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT11 = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  logic       hs_q, hs_qq, vs_q, vs_qq;
  logic       hs_act, hs_act_d, vs_act, vs_act_d;
  logic       ls, fe, fs;
  logic       vs_pend;
  logic [9:0] hpos, vpos;
  logic       line_ok, frame_ok, h_to, v_to, violation;
  logic [1:0] state, state_nx;
  logic [3:0] good_cnt, good_nx, good_inc;
  logic       ha, va, disp_nx, is_locked;

  // Two-stage input registers; reset parks them at the inactive level so
  // the first active sample after reset is seen as an edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_q  <= ~ACT;
      hs_qq <= ~ACT;
      vs_q  <= ~ACT;
      vs_qq <= ~ACT;
    end else begin
      hs_q  <= hsync;
      hs_qq <= hs_q;
      vs_q  <= vsync;
      vs_qq <= vs_q;
    end
  end

  assign hs_act   = (hs_q  == ACT);
  assign hs_act_d = (hs_qq == ACT);
  assign vs_act   = (vs_q  == ACT);
  assign vs_act_d = (vs_qq == ACT);

  assign ls = hs_act & ~hs_act_d;
  assign fe = vs_act & ~vs_act_d;
  // A vsync edge is held pending until the next line start, which becomes the frame start.
  assign fs = ls & (vs_pend | fe);

  assign line_ok  = (({1'b0, hpos} + 11'd1) == H_TOT11);
  assign frame_ok = (({1'b0, vpos} + 11'd1) == V_TOT11);
  assign h_to     = &hpos;
  assign v_to     = &vpos;

  assign violation = (state != ST_SEARCH) &
                     ((ls & ~line_ok) | (fs & ~frame_ok) | h_to | v_to);

  always_ff @(posedge pclk) begin
    if (rst) begin
      hpos    <= '0;
      vpos    <= '0;
      vs_pend <= 1'b0;
    end else begin
      if (ls)
        hpos <= '0;
      else if (!h_to)
        hpos <= hpos + 10'd1;

      if (fs)
        vpos <= '0;
      else if (ls && !v_to)
        vpos <= vpos + 10'd1;

      if (fs)
        vs_pend <= 1'b0;
      else if (fe)
        vs_pend <= 1'b1;
    end
  end

  assign good_inc = good_cnt + 4'd1;

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    case (state)
      ST_SEARCH: begin
        if (fs) begin
          state_nx = ST_VERIFY;
          good_nx  = '0;
        end
      end
      ST_VERIFY: begin
        if (violation) begin
          state_nx = ST_SEARCH;
        end else if (fs) begin
          good_nx = good_inc;
          if (good_inc == LOCK_N)
            state_nx = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (violation)
          state_nx = ST_SEARCH;
      end
      default: state_nx = ST_SEARCH;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  // Outputs use the pre-transition state, so they trail the counters by one edge.
  assign is_locked = (state == ST_LOCKED);
  assign ha        = (hpos >= H_START) && (hpos < H_END);
  assign va        = (vpos >= V_START) && (vpos < V_END);
  assign disp_nx   = is_locked & ha & va;

  always_ff @(posedge pclk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      display     <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      x           <= disp_nx ? (hpos - H_START) : '0;
      y           <= disp_nx ? (vpos - V_START) : '0;
      display     <= disp_nx;
      locked      <= is_locked;
      frame_start <= fs & is_locked;
      err         <= violation;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down sync generator drives an active-low
// and an active-high decoder; a timing model feeds a scoreboard of expected outputs.
module tb_vga_sync_decoder;

  localparam int HA = 16, HS = 4, HB = 4, HT = 30;
  localparam int VA = 6,  VS = 2, VB = 2, VT = 12;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;
  localparam int MS = 0, MV = 1, ML = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       disp;
    logic       lck;
  } exp_t;

  typedef struct packed {
    logic fst;
    logic er;
  } pulse_t;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic hsync = 1'b1;
  logic vsync = 1'b1;
  logic hs_inv, vs_inv;
  logic [9:0] x0, y0, x1, y1;
  logic disp0, lck0, fst0, err0, disp1, lck1, fst1, err1;

  int errors = 0;
  int checks = 0;

  exp_t   qm[$];
  pulse_t qp[$];

  // generator position and scenario knobs
  int gh = 0, gv = 0, cur_len = HT;
  bit hold = 0, early = 0;
  // timing model
  int since = 0, vl = 0, mgood = 0, mst = MS;

  assign hs_inv = ~hsync;
  assign vs_inv = ~vsync;

  always #5 pclk = ~pclk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(0), .LOCK_FRAMES(LF)
  ) dut0 (
    .pclk(pclk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .x(x0), .y(y0), .display(disp0), .locked(lck0),
    .frame_start(fst0), .err(err0)
  );

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(1), .LOCK_FRAMES(LF)
  ) dut1 (
    .pclk(pclk), .rst(rst), .hsync(hs_inv), .vsync(vs_inv),
    .x(x1), .y(y1), .display(disp1), .locked(lck1),
    .frame_start(fst1), .err(err1)
  );

  // One pixel of stimulus; the model decides what the decoder must show for it.
  task automatic cyc(input bit do_rst);
    bit ls, fs, viol, hs_on, vs_on;
    exp_t e;
    pulse_t p;
    @(negedge pclk);
    hs_on = (gh < HS) && !hold;
    vs_on = (gv < VS) || (early && gv == VT - 1 && gh >= HT / 2 && gh != HT / 2 + 2);
    hsync = ~hs_on;
    vsync = ~vs_on;
    rst   = do_rst;
    if (do_rst) begin
      qm.delete();
      qp.delete();
      mst = MS; mgood = 0; since = 0; vl = 0;
    end else begin
      ls   = (gh == 0) && !hold;
      fs   = ls && (gv == 0);
      viol = (mst != MS) && ((ls && since + 1 != HT) || (fs && vl + 1 != VT) || since >= 1023);
      p.er  = viol;
      p.fst = fs && (mst == ML);
      if (ls) since = 0;
      else if (since < 1023) since++;
      if (fs) vl = 0;
      else if (ls) vl++;
      if (viol) mst = MS;
      else if (fs) begin
        if (mst == MS) begin
          mst = MV; mgood = 0;
        end else if (mst == MV) begin
          mgood++;
          if (mgood == LF) mst = ML;
        end
      end
      e.lck  = (mst == ML);
      e.disp = e.lck && since >= HS + HB && since < HS + HB + HA && vl >= VS + VB && vl < VS + VB + VA;
      e.x    = e.disp ? 10'(since - (HS + HB)) : 10'd0;
      e.y    = e.disp ? 10'(vl - (VS + VB)) : 10'd0;
      qm.push_back(e);
      qp.push_back(p);
    end
    gh++;
    if (gh >= cur_len) begin
      gh = 0;
      cur_len = HT;
      gv = (gv + 1) % VT;
    end
  endtask

  // Scoreboard: level outputs trail stimulus by two edges, pulses by one.
  initial begin
    exp_t e;
    pulse_t p;
    forever begin
      @(posedge pclk);
      #1;
      if (qm.size() > 2) begin
        e = qm.pop_front();
        checks += 8;
        if (x0 !== e.x) begin errors++; $display("FAIL sb_x0 t=%0t got %0d exp %0d", $time, x0, e.x); end
        if (y0 !== e.y) begin errors++; $display("FAIL sb_y0 t=%0t got %0d exp %0d", $time, y0, e.y); end
        if (disp0 !== e.disp) begin errors++; $display("FAIL sb_disp0 t=%0t got %0b exp %0b", $time, disp0, e.disp); end
        if (lck0 !== e.lck) begin errors++; $display("FAIL sb_lock0 t=%0t got %0b exp %0b", $time, lck0, e.lck); end
        if (x1 !== e.x) begin errors++; $display("FAIL sb_x1 t=%0t got %0d exp %0d", $time, x1, e.x); end
        if (y1 !== e.y) begin errors++; $display("FAIL sb_y1 t=%0t got %0d exp %0d", $time, y1, e.y); end
        if (disp1 !== e.disp) begin errors++; $display("FAIL sb_disp1 t=%0t got %0b exp %0b", $time, disp1, e.disp); end
        if (lck1 !== e.lck) begin errors++; $display("FAIL sb_lock1 t=%0t got %0b exp %0b", $time, lck1, e.lck); end
      end
      if (qp.size() > 1) begin
        p = qp.pop_front();
        checks += 4;
        if (fst0 !== p.fst) begin errors++; $display("FAIL sb_fstart0 t=%0t got %0b exp %0b", $time, fst0, p.fst); end
        if (err0 !== p.er) begin errors++; $display("FAIL sb_err0 t=%0t got %0b exp %0b", $time, err0, p.er); end
        if (fst1 !== p.fst) begin errors++; $display("FAIL sb_fstart1 t=%0t got %0b exp %0b", $time, fst1, p.fst); end
        if (err1 !== p.er) begin errors++; $display("FAIL sb_err1 t=%0t got %0b exp %0b", $time, err1, p.er); end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1);
    @(posedge pclk);
    #1;
    checks += 7;
    if (x0 !== 10'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", x0); end
    if (y0 !== 10'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", y0); end
    if (disp0 !== 1'b0) begin errors++; $display("FAIL rst_disp got %0b exp 0", disp0); end
    if (lck0 !== 1'b0) begin errors++; $display("FAIL rst_lock got %0b exp 0", lck0); end
    if (fst0 !== 1'b0) begin errors++; $display("FAIL rst_fstart got %0b exp 0", fst0); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err0); end
    if (lck1 !== 1'b0) begin errors++; $display("FAIL rst_lock1 got %0b exp 0", lck1); end
    gh = 0; gv = 0; cur_len = HT;
  endtask

  task automatic test_clean_lock();
    int dcnt = 0, fcnt = 0, ecnt = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      cyc(1'b0);
      if (disp0) dcnt++;
      if (fst0) fcnt++;
      if (err0) ecnt++;
    end
    checks += 4;
    // frames 2..4 are displayed (lock lands before frame 2's first active line)
    if (dcnt != 3 * HA * VA) begin errors++; $display("FAIL clean_disp_cycles got %0d exp %0d", dcnt, 3 * HA * VA); end
    if (fcnt != 2) begin errors++; $display("FAIL clean_fstart_count got %0d exp 2", fcnt); end
    if (ecnt != 0) begin errors++; $display("FAIL clean_err_count got %0d exp 0", ecnt); end
    if (lck0 !== 1'b1) begin errors++; $display("FAIL clean_locked got %0b exp 1", lck0); end
  endtask

  task automatic test_short_line();
    int ecnt = 0, unl = 0;
    for (int i = 0; i < 2 * FRAME && !(gh == 0 && gv == 3); i++) cyc(1'b0);
    cur_len = HT - 1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      cyc(1'b0);
      if (err0) ecnt++;
      if (!lck0) unl++;
    end
    checks += 3;
    if (ecnt != 1) begin errors++; $display("FAIL short_err_count got %0d exp 1", ecnt); end
    if (unl == 0) begin errors++; $display("FAIL short_unlock got %0d low cycles exp >0", unl); end
    if (lck0 !== 1'b1) begin errors++; $display("FAIL short_relock got %0b exp 1", lck0); end
  endtask

  task automatic test_rst_midframe();
    for (int i = 0; i < 2 * FRAME && !(gh == 12 && gv == 5); i++) cyc(1'b0);
    cyc(1'b1);
    @(posedge pclk);
    #1;
    checks += 5;
    if (x0 !== 10'd0) begin errors++; $display("FAIL mid_rst_x got %0d exp 0", x0); end
    if (y0 !== 10'd0) begin errors++; $display("FAIL mid_rst_y got %0d exp 0", y0); end
    if (disp0 !== 1'b0) begin errors++; $display("FAIL mid_rst_disp got %0b exp 0", disp0); end
    if (lck0 !== 1'b0) begin errors++; $display("FAIL mid_rst_lock got %0b exp 0", lck0); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %0b exp 0", err0); end
    for (int i = 0; i < 4 * FRAME; i++) cyc(1'b0);
    checks++;
    if (lck0 !== 1'b1) begin errors++; $display("FAIL mid_rst_relock got %0b exp 1", lck0); end
  endtask

  // vsync leads hsync by half a line and glitches once: fs must still land on line start
  task automatic test_vs_early();
    int ecnt = 0, unl = 0;
    early = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cyc(1'b0);
      if (err0) ecnt++;
      if (!lck0) unl++;
    end
    early = 0;
    checks += 2;
    if (ecnt != 0) begin errors++; $display("FAIL early_err_count got %0d exp 0", ecnt); end
    if (unl != 0) begin errors++; $display("FAIL early_unlock got %0d low cycles exp 0", unl); end
  endtask

  task automatic test_hsync_timeout();
    int ecnt = 0;
    for (int i = 0; i < 2 * FRAME && !(gh == 1 && gv == 5); i++) cyc(1'b0);
    hold = 1;
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b0);
      if (err0) ecnt++;
    end
    checks += 2;
    if (ecnt != 1) begin errors++; $display("FAIL timeout_err_count got %0d exp 1", ecnt); end
    if (lck0 !== 1'b0) begin errors++; $display("FAIL timeout_locked got %0b exp 0", lck0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_short_line();
    test_rst_midframe();
    test_vs_early();
    test_hsync_timeout();
    @(posedge pclk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
